// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle MIPS control FSM.
// The TRAP state exists only when ILLEGAL_TRAP_EN is defined.
package multicycle_control_pkg;

  localparam int OP_W    = 6;
  localparam int ALUOP_W = 4;
  localparam int STATE_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OP_W-1:0] OP_J     = 6'd2;
  localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
  localparam logic [OP_W-1:0] OP_BNE   = 6'd5;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd8;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd10;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'd12;
  localparam logic [OP_W-1:0] OP_ORI   = 6'd13;
  localparam logic [OP_W-1:0] OP_XORI  = 6'd14;
  localparam logic [OP_W-1:0] OP_LW    = 6'd35;
  localparam logic [OP_W-1:0] OP_SW    = 6'd43;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 4'b0011;
  localparam logic [ALUOP_W-1:0] ALU_XOR   = 4'b0100;
  localparam logic [ALUOP_W-1:0] ALU_SLT   = 4'b0101;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 4'b1111;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_RA  = 2'b10;
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;
  localparam logic       SRCA_PC = 1'b0;
  localparam logic       SRCA_A  = 1'b1;
  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;
  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_OUT = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;

  // j and jal share S_JUMP; op_q selects the link write
  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_R_EXEC    = 4'd3,
    S_I_EXEC    = 4'd4,
    S_ALU_WB    = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
`ifdef ILLEGAL_TRAP_EN
    ,S_TRAP     = 4'd12
`endif
  } state_t;

  typedef struct packed {
    logic               pc_write;
    logic               ir_write;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic               imm_zext;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_src;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_out_decode.sv
// Combinational output decode: state + latched opcode -> datapath controls.
// Only FETCH (mem_ready) and BRANCH (zero) look at live inputs.
module mc_out_decode
  import multicycle_control_pkg::*;
(
  input  state_t          state,
  input  logic [OP_W-1:0] op_q,
  input  logic            zero,
  input  logic            mem_ready,
  output ctrl_t           ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCS_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_BR;
        ctrl.alu_op    = ALU_ADD;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_IMM;
        unique case (op_q)
          OP_SLTI: ctrl.alu_op = ALU_SLT;
          OP_ANDI: begin
            ctrl.alu_op   = ALU_AND;
            ctrl.imm_zext = 1'b1;
          end
          OP_ORI: begin
            ctrl.alu_op   = ALU_OR;
            ctrl.imm_zext = 1'b1;
          end
          OP_XORI: begin
            ctrl.alu_op   = ALU_XOR;
            ctrl.imm_zext = 1'b1;
          end
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      S_ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = (op_q == OP_RTYPE) ? RD_RD : RD_RT;
        ctrl.mem_to_reg = M2R_ALU;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ:  ctrl.mem_read = 1'b1;
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RD_RT;
        ctrl.mem_to_reg = M2R_MDR;
      end
      S_MEM_WRITE: ctrl.mem_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PCS_OUT;
        ctrl.pc_write  = (op_q == OP_BEQ) ? zero : ~zero;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCS_JMP;
        if (op_q == OP_JAL) begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = RD_RA;
          ctrl.mem_to_reg = M2R_PC;
        end
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state and op_q registers, next-state logic.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes instead of treating them as NOPs.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               imm_zext,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  state_t          state, state_d;
  logic [OP_W-1:0] op_q;
  ctrl_t           ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= '0;
    end else begin
      state <= state_d;
      if (state == S_DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          opcode == OP_RTYPE: state_d = S_R_EXEC;
          opcode == OP_ADDI,
          opcode == OP_SLTI,
          opcode == OP_ANDI,
          opcode == OP_ORI,
          opcode == OP_XORI:  state_d = S_I_EXEC;
          opcode == OP_BEQ,
          opcode == OP_BNE:   state_d = S_BRANCH;
          opcode == OP_LW,
          opcode == OP_SW:    state_d = S_MEM_ADDR;
          opcode == OP_J,
          opcode == OP_JAL:   state_d = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:            state_d = S_TRAP;
`else
          default:            state_d = S_FETCH;
`endif
        endcase
      end
      S_R_EXEC,
      S_I_EXEC:    state_d = S_ALU_WB;
      S_MEM_ADDR:  state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_ALU_WB,
      S_MEM_WB,
      S_BRANCH,
      S_JUMP:      state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:      state_d = S_TRAP;
`endif
      default:     state_d = S_IDLE;
    endcase
  end

  mc_out_decode u_dec (
    .state     (state),
    .op_q      (op_q),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write   = ctrl.pc_write;
  assign ir_write   = ctrl.ir_write;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign reg_write  = ctrl.reg_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign imm_zext   = ctrl.imm_zext;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign state_o    = state;

`ifdef ILLEGAL_TRAP_EN
  // TRAP is only left through reset, so the state itself is the sticky flag
  assign illegal_op = (state == S_TRAP);
`else
  assign illegal_op = 1'b0;
`endif

endmodule
